// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-port data memory between the CPU load/store
// path and a host port (debug, preload, readback). One owner per cycle; the CPU
// has default priority and a saturating wait counter forces a host grant.
module dm_port_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int AW       = 16,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    // CPU load/store path
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    // host port
    input  logic          host_valid,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    // data memory side
    output logic          dm_we,
    output logic [DW-1:0] dm_d,
    output logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_q
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    // FORCED marks that the previous cycle was a forced host grant, so the CPU
    // gets the next cycle and the host can never monopolise the memory.
    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;
    logic          cpu_grant;
    logic          host_grant;
    logic          host_rd_grant;

    // host read return stage
    logic          rd_vld_p1;
    logic [DW-1:0] rdata_p1;

    // Grant decision and next state; reset blocks every grant in its own cycle.
    always_comb begin
        cpu_grant  = 1'b0;
        host_grant = 1'b0;
        state_next = ST_NORMAL;
        if (!rst) begin
            case (state)
                ST_NORMAL: begin
                    if (host_valid && (!cpu_req || (wait_cnt == MAX_CNT))) begin
                        host_grant = 1'b1;
                    end else if (cpu_req) begin
                        cpu_grant = 1'b1;
                    end
                end
                ST_FORCED: begin
                    if (cpu_req) begin
                        cpu_grant = 1'b1;
                    end else if (host_valid) begin
                        host_grant = 1'b1;
                    end
                end
                default: begin
                    cpu_grant  = 1'b0;
                    host_grant = 1'b0;
                end
            endcase
            // A host grant while the CPU is asking can only be the forced one.
            if (host_grant && cpu_req) begin
                state_next = ST_FORCED;
            end
        end
    end

    // Wait counter: counts cycles the host is refused, saturates at MAX_WAIT.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (host_grant || !host_valid) begin
            wait_cnt_next = '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt_next = wait_cnt + 1'b1;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Memory port mux; with no owner the CPU payload is presented but never written.
    always_comb begin
        dm_addr = cpu_addr;
        dm_d    = cpu_wdata;
        dm_we   = 1'b0;
        if (host_grant) begin
            dm_addr = host_addr;
            dm_d    = host_wdata;
            dm_we   = host_we;
        end else if (cpu_grant) begin
            dm_we   = cpu_we;
        end
    end

    assign host_rd_grant = host_grant && !host_we;

    // ---- stage p0 -> p1: capture host read data at the end of its grant cycle ----
    // Read valid pulses for one cycle; read data holds until the next host read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
            rdata_p1  <= '0;
        end else begin
            rd_vld_p1 <= host_rd_grant;
            if (host_rd_grant) begin
                rdata_p1 <= dm_q;
            end
        end
    end

    assign cpu_rdata   = dm_q;
    assign cpu_stall   = cpu_req && !cpu_grant && !rst;
    assign host_ready  = host_grant;
    assign host_rvalid = rd_vld_p1;
    assign host_rdata  = rdata_p1;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Testbench for dm_port_arbiter: directed vectors with a behavioural data memory,
// host read returns checked by a scoreboard monitor.
module tb_dm_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          host_valid;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ready;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          dm_we;
    logic [DW-1:0] dm_d;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_q;

    always #5 clk = ~clk;

    dm_port_arbiter #(.MAX_WAIT(MW), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_valid (host_valid),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .dm_we      (dm_we),
        .dm_d       (dm_d),
        .dm_addr    (dm_addr),
        .dm_q       (dm_q)
    );

    // behavioural DATA_MEMORY: synchronous write, combinational read
    logic [DW-1:0] mem [0:15];
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[3:0]] <= dm_d;
    end
    assign dm_q = mem[dm_addr[3:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (host_rvalid === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rvalid_unexpected: host_rvalid=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at != cyc || host_rdata !== e.data) begin
                        n_fail++;
                        $display("FAIL host_rdata: got %h at cycle %0d, required %h at cycle %0d",
                                 host_rdata, cyc, e.data, e.at);
                    end
                end
            end
        end
    endtask

    task automatic set_in(input logic cr, input logic cw, input logic [AW-1:0] ca,
                          input logic [DW-1:0] cd, input logic hv, input logic hw,
                          input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        cpu_req    = cr;
        cpu_we     = cw;
        cpu_addr   = ca;
        cpu_wdata  = cd;
        host_valid = hv;
        host_we    = hw;
        host_addr  = ha;
        host_wdata = hd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [DW-1:0] d);
        exp_t e;
        e.data = d;
        e.at   = cyc + 1;
        exp_q.push_back(e);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset with requests active: nothing may be granted
        rst = 1'b1;
        set_in(1, 1, 2, 32'd7, 1, 1, 3, 32'd5);
        @(negedge clk);
        chk("rst_host_ready", {31'b0, host_ready}, 0);
        chk("rst_dm_we", {31'b0, dm_we}, 0);
        chk("rst_cpu_stall", {31'b0, cpu_stall}, 0);
        tick();
        @(negedge clk);
        chk("rst_host_rvalid", {31'b0, host_rvalid}, 0);
        chk("rst_host_rdata", host_rdata, 0);

        // CPU-only store
        tick();
        rst = 1'b0;
        set_in(1, 1, 2, 32'd7, 0, 0, 0, 0);
        @(negedge clk);
        chk("cpu_st_dm_we", {31'b0, dm_we}, 1);
        chk("cpu_st_stall", {31'b0, cpu_stall}, 0);
        chk("cpu_st_host_ready", {31'b0, host_ready}, 0);
        chk("cpu_st_dm_addr", {16'b0, dm_addr}, 2);
        chk("cpu_st_dm_d", dm_d, 7);
        // no owner: CPU payload on the bus, never written
        tick();
        set_in(0, 1, 9, 32'h55, 0, 0, 0, 0);
        @(negedge clk);
        chk("mem2_after_store", mem[2], 7);
        chk("idle_dm_we", {31'b0, dm_we}, 0);
        chk("idle_dm_addr", {16'b0, dm_addr}, 9);
        chk("idle_dm_d", dm_d, 32'h55);
        chk("idle_cpu_stall", {31'b0, cpu_stall}, 0);

        // host-only: write mem[1]=3, then read addr 1
        tick();
        set_in(0, 0, 0, 0, 1, 1, 1, 32'd3);
        @(negedge clk);
        chk("hwr1_ready", {31'b0, host_ready}, 1);
        chk("hwr1_dm_we", {31'b0, dm_we}, 1);
        chk("hwr1_dm_addr", {16'b0, dm_addr}, 1);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 1, 0);
        push_rd(32'd3);
        @(negedge clk);
        chk("hrd1_ready", {31'b0, host_ready}, 1);
        chk("hrd1_dm_we", {31'b0, dm_we}, 0);
        chk("hrd1_no_rvalid_after_write", {31'b0, host_rvalid}, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("hrd1_rvalid_n2", {31'b0, host_rvalid}, 0);
        chk("hrd1_rdata_hold", host_rdata, 3);

        // host write 5=A5A5A5A5 then read back-to-back, then an unrelated write
        tick();
        set_in(0, 0, 0, 0, 1, 1, 5, 32'hA5A5A5A5);
        @(negedge clk);
        chk("hwr5_ready", {31'b0, host_ready}, 1);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 5, 0);
        push_rd(32'hA5A5A5A5);
        @(negedge clk);
        chk("hrd5_ready", {31'b0, host_ready}, 1);
        tick();
        set_in(0, 0, 0, 0, 1, 1, 6, 32'h12345678);
        @(negedge clk);
        chk("hwr6_ready", {31'b0, host_ready}, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hwr6_no_rvalid", {31'b0, host_rvalid}, 0);
        chk("hwr6_rdata_hold", host_rdata, 32'hA5A5A5A5);

        // starvation: CPU wins MW cycles, forced host grant, then CPU again
        for (int k = 1; k <= MW + 2; k++) begin
            tick();
            set_in(1, 0, 0, 0, 1, 0, 1, 0);
            if (k == MW + 1) push_rd(32'd3);
            @(negedge clk);
            if (k == MW + 1) begin
                chk($sformatf("starve_ready_c%0d", k), {31'b0, host_ready}, 1);
                chk($sformatf("starve_stall_c%0d", k), {31'b0, cpu_stall}, 1);
                chk("starve_dm_addr", {16'b0, dm_addr}, 1);
            end else begin
                chk($sformatf("starve_ready_c%0d", k), {31'b0, host_ready}, 0);
                chk($sformatf("starve_stall_c%0d", k), {31'b0, cpu_stall}, 0);
            end
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // same-address conflict: mem[4]=1, CPU load vs host write 4=9
        tick();
        set_in(0, 0, 0, 0, 1, 1, 4, 32'd1);
        @(negedge clk);
        chk("hwr4_ready", {31'b0, host_ready}, 1);
        tick();
        set_in(1, 0, 4, 0, 1, 1, 4, 32'd9);
        @(negedge clk);
        chk("conf_cpu_rdata", cpu_rdata, 1);
        chk("conf_host_ready", {31'b0, host_ready}, 0);
        chk("conf_cpu_stall", {31'b0, cpu_stall}, 0);
        chk("conf_dm_we", {31'b0, dm_we}, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 1, 4, 32'd9);
        @(negedge clk);
        chk("conf_host_ready_next", {31'b0, host_ready}, 1);
        chk("conf_dm_we_next", {31'b0, dm_we}, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("conf_mem4", mem[4], 9);

        // build wait_cnt=3, then reset with the host request still pending
        for (int k = 1; k <= 3; k++) begin
            tick();
            set_in(1, 0, 0, 0, 1, 0, 5, 0);
            @(negedge clk);
            chk($sformatf("prerst_ready_c%0d", k), {31'b0, host_ready}, 0);
        end
        tick();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 1, 0, 5, 0);
        @(negedge clk);
        chk("midrst_host_ready", {31'b0, host_ready}, 0);
        chk("midrst_dm_we", {31'b0, dm_we}, 0);
        chk("midrst_cpu_stall", {31'b0, cpu_stall}, 0);
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("postrst_rvalid", {31'b0, host_rvalid}, 0);
        chk("postrst_rdata", host_rdata, 0);
        chk("postrst_dm_we", {31'b0, dm_we}, 0);
        // cleared counter: host must again wait the full MW cycles
        for (int k = 1; k <= MW + 1; k++) begin
            tick();
            set_in(1, 0, 0, 0, 1, 0, 5, 0);
            if (k == MW + 1) push_rd(32'hA5A5A5A5);
            @(negedge clk);
            chk($sformatf("postrst_ready_c%0d", k), {31'b0, host_ready}, (k == MW + 1) ? 1 : 0);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
